serial_frame_tx: RTL and testbench

Parallel-to-serial frame source that drives the bit-serial `din` input of the sequence-detecting Mealy stage.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out LSB-first, one bit per clock, with a qualifier.
- Inserts a programmable idle gap between frames so the downstream detector sees well-defined frame boundaries.

---
 rtl/ser_pkg.sv | 13 +
 rtl/serial_frame_tx.sv | 126 ++++++++++++
 tb/tb_serial_frame_tx.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared types for the serial frame source: FSM state encoding and the
// width of the inter-frame gap counter.
package ser_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: accepts a WIDTH-bit word over valid/ready and shifts it
// out LSB-first, one bit per clock, followed by GAP_CYCLES idle cycles.
// Optional build macro SER_PARITY_EN appends an even-parity bit after the
// data bits and moves frame_done onto that extra cycle.
module serial_frame_tx
    import ser_pkg::*;
#(
    parameter int WIDTH      = 11,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SER_PARITY_EN
    localparam int LAST_IDX = WIDTH;
`else
    localparam int LAST_IDX = WIDTH - 1;
`endif
    localparam logic [CNT_W-1:0]     LAST     = CNT_W'(LAST_IDX);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST =
        GAP_CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t               r_state;
    // Holds the bits not yet driven; bit 0 is the next one out.
    logic [WIDTH-1:0]     r_shreg;
    // Index of the bit currently on dout.
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [GAP_CNT_W-1:0] r_gap_cnt;
    logic                 r_dout;
    logic                 r_dout_valid;
    logic                 r_frame_done;
    logic                 r_busy;
`ifdef SER_PARITY_EN
    logic                 r_par;
`endif

    logic [CNT_W-1:0]     w_bit_nxt;

    assign w_bit_nxt  = r_bit_cnt + CNT_W'(1);
    assign load_ready = (r_state == S_IDLE);
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;

    // Frame FSM with all serial-side outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
`ifdef SER_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load_valid) begin
                        // Bit 0 goes straight to dout so it appears the
                        // cycle after the accept edge.
                        r_shreg      <= {1'b0, load_data[WIDTH-1:1]};
                        r_dout       <= load_data[0];
                        r_dout_valid <= 1'b1;
                        r_frame_done <= 1'b0;
                        r_busy       <= 1'b1;
                        r_bit_cnt    <= '0;
                        r_state      <= S_SHIFT;
`ifdef SER_PARITY_EN
                        r_par        <= ^load_data;
`endif
                    end
                end
                S_SHIFT: begin
                    if (r_bit_cnt == LAST) begin
                        r_dout       <= 1'b0;
                        r_dout_valid <= 1'b0;
                        r_frame_done <= 1'b0;
                        r_gap_cnt    <= '0;
                        if (GAP_CYCLES == 0) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end else begin
`ifdef SER_PARITY_EN
                        r_dout <= (w_bit_nxt == CNT_W'(WIDTH)) ? r_par : r_shreg[0];
`else
                        r_dout <= r_shreg[0];
`endif
                        r_shreg      <= {1'b0, r_shreg[WIDTH-1:1]};
                        r_bit_cnt    <= w_bit_nxt;
                        r_frame_done <= (w_bit_nxt == LAST);
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: accepted loads push expected
// (bit, frame_done) pairs; a negedge monitor pops and compares each valid bit.
// A second instance with GAP_CYCLES=0 checks the zero-gap turnaround.
module tb_serial_frame_tx;

    localparam int W = 11;
`ifdef SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = W + PAR;

    typedef struct packed {
        logic b;
        logic fd;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         lv = 1'b0, lv0 = 1'b0;
    logic [W-1:0] ld = '0, ld0 = '0;
    logic         load_ready, dout, dout_valid, frame_done, busy;
    logic         load_ready0, dout0, dout_valid0, frame_done0, busy0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc[$];
    exp_t q[$];
    exp_t q0[$];

    serial_frame_tx #(.WIDTH(W), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .load_valid(lv), .load_data(ld),
        .load_ready(load_ready), .dout(dout), .dout_valid(dout_valid),
        .frame_done(frame_done), .busy(busy)
    );

    serial_frame_tx #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .load_valid(lv0), .load_data(ld0),
        .load_ready(load_ready0), .dout(dout0), .dout_valid(dout_valid0),
        .frame_done(frame_done0), .busy(busy0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected-frame generation on every accepting edge of the main DUT.
    always @(posedge clk) begin
        exp_t e;
        if (reset && lv && load_ready) begin
            acc_cyc.push_back(cyc);
            for (int i = 0; i < W; i++) begin
                e.b  = ld[i];
                e.fd = (i == NB - 1);
                q.push_back(e);
            end
            if (PAR != 0) begin
                e.b  = ^ld;
                e.fd = 1'b1;
                q.push_back(e);
            end
        end
    end

    // Expected-frame generation for the zero-gap instance.
    always @(posedge clk) begin
        exp_t e;
        if (reset && lv0 && load_ready0) begin
            for (int i = 0; i < W; i++) begin
                e.b  = ld0[i];
                e.fd = (i == NB - 1);
                q0.push_back(e);
            end
            if (PAR != 0) begin
                e.b  = ^ld0;
                e.fd = 1'b1;
                q0.push_back(e);
            end
        end
    end

    // Monitor for the main DUT.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (dout_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: got dout=%0b with nothing expected", dout);
                end else begin
                    e = q.pop_front();
                    chk("dout", {31'd0, dout}, {31'd0, e.b});
                    chk("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
                end
            end else begin
                chk("idle_dout", {31'd0, dout}, 32'd0);
                chk("idle_frame_done", {31'd0, frame_done}, 32'd0);
            end
        end
    end

    // Monitor for the zero-gap DUT.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (dout_valid0) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit0: got dout=%0b with nothing expected", dout0);
                end else begin
                    e = q0.pop_front();
                    chk("dout0", {31'd0, dout0}, {31'd0, e.b});
                    chk("frame_done0", {31'd0, frame_done0}, {31'd0, e.fd});
                end
            end else begin
                chk("idle_dout0", {31'd0, dout0}, 32'd0);
            end
        end
    end

    task automatic wait_acc(input int n, input string nm);
        bit found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (acc_cyc.size() > n) begin
                found = 1;
                break;
            end
        end
        chk(nm, {31'd0, found}, 32'd1);
    endtask

    task automatic wait_fd(input string nm);
        bit found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done) begin
                found = 1;
                break;
            end
        end
        chk(nm, {31'd0, found}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit found;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dout", {31'd0, dout}, 32'd0);
        chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, load_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Single frame, then gap timing
        n = acc_cyc.size();
        lv = 1'b1;
        ld = 11'b10101001010;
        wait_acc(n, "accept1");
        lv = 1'b0;
        wait_fd("frame1_done");
        repeat (2) begin
            @(negedge clk);
            chk("gap_valid", {31'd0, dout_valid}, 32'd0);
            chk("gap_busy", {31'd0, busy}, 32'd1);
            chk("gap_ready", {31'd0, load_ready}, 32'd0);
        end
        @(negedge clk);
        chk("after_gap_ready", {31'd0, load_ready}, 32'd1);
        chk("after_gap_busy", {31'd0, busy}, 32'd0);

        // Back-to-back with load_valid held high
        n = acc_cyc.size();
        lv = 1'b1;
        ld = 11'h7FF;
        wait_acc(n, "b2b_accept_a");
        ld = 11'h000;
        wait_acc(n + 1, "b2b_accept_b");
        lv = 1'b0;
        if (acc_cyc.size() >= n + 2)
            chk("b2b_period", acc_cyc[n+1] - acc_cyc[n], NB + 3);
        wait_fd("b2b_done");
        repeat (3) @(negedge clk);

        // Input churn during SHIFT has no effect
        n = acc_cyc.size();
        lv = 1'b1;
        ld = 11'h5A3;
        wait_acc(n, "churn_accept");
        for (int k = 0; k < 8; k++) begin
            chk("churn_ready", {31'd0, load_ready}, 32'd0);
            lv = 1'b1;
            ld = 11'($urandom);
            @(negedge clk);
        end
        lv = 1'b0;
        chk("churn_accepts", acc_cyc.size(), n + 1);
        wait_fd("churn_done");
        repeat (3) @(negedge clk);

        // Reset in the middle of a frame
        n = acc_cyc.size();
        lv = 1'b1;
        ld = 11'h3A5;
        wait_acc(n, "abort_accept");
        lv = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        q.delete();
        #1;
        chk("abort_dout", {31'd0, dout}, 32'd0);
        chk("abort_valid", {31'd0, dout_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_fd", {31'd0, frame_done}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_fd_hold", {31'd0, frame_done}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        n = acc_cyc.size();
        lv = 1'b1;
        ld = 11'b00000000001;
        wait_acc(n, "post_abort_accept");
        lv = 1'b0;
        wait_fd("post_abort_done");
        repeat (3) @(negedge clk);

        // Zero-gap instance
        lv0 = 1'b1;
        ld0 = 11'h2C3;
        @(negedge clk);
        lv0 = 1'b0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done0) begin
                found = 1;
                break;
            end
        end
        chk("gap0_done", {31'd0, found}, 32'd1);
        @(negedge clk);
        chk("gap0_ready", {31'd0, load_ready0}, 32'd1);
        chk("gap0_busy", {31'd0, busy0}, 32'd0);
        chk("gap0_valid", {31'd0, dout_valid0}, 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_empty", q.size(), 32'd0);
        chk("sb0_empty", q0.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
